// File: rtl/operand_fetch.sv
// Operand fetch stage: register-file read addressing, writeback forwarding, RAW/WAW
// scoreboard stalls and a registered valid/ready output slot toward execute.
module operand_fetch #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [ADDR_WIDTH-1:0]       in_ra,
    input  logic [ADDR_WIDTH-1:0]       in_rb,
    input  logic [ADDR_WIDTH-1:0]       in_rc,
    input  logic                        in_use_a,
    input  logic                        in_use_b,
    input  logic                        in_wr,
    output logic [ADDR_WIDTH-1:0]       rf_ra,
    output logic [ADDR_WIDTH-1:0]       rf_rb,
    input  logic [DATA_WIDTH-1:0]       rf_rd1,
    input  logic [DATA_WIDTH-1:0]       rf_rd2,
    input  logic                        wb_valid,
    input  logic [ADDR_WIDTH-1:0]       wb_rc,
    input  logic [DATA_WIDTH-1:0]       wb_data,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [DATA_WIDTH-1:0]       out_a,
    output logic [DATA_WIDTH-1:0]       out_b,
    output logic [ADDR_WIDTH-1:0]       out_rc,
    output logic                        out_wr,
    output logic [(2**ADDR_WIDTH)-1:0]  busy,
    output logic [CNT_WIDTH-1:0]        stall_count
);

    localparam int NREGS = 2**ADDR_WIDTH;

    logic [NREGS-1:0]      r_busy;
    logic [NREGS-1:0]      w_busy_next;
    logic                  r_out_valid;
    logic [DATA_WIDTH-1:0] r_out_a;
    logic [DATA_WIDTH-1:0] r_out_b;
    logic [ADDR_WIDTH-1:0] r_out_rc;
    logic                  r_out_wr;
    logic [CNT_WIDTH-1:0]  r_stall_count;

    logic                  w_fwd_a;
    logic                  w_fwd_b;
    logic                  w_fwd_w;
    logic                  w_hz_a;
    logic                  w_hz_b;
    logic                  w_hz_w;
    logic                  w_space;
    logic                  w_ready;
    logic                  w_accept;
    logic                  w_stall;
    logic [DATA_WIDTH-1:0] w_op_a;
    logic [DATA_WIDTH-1:0] w_op_b;

    assign rf_ra = in_ra;
    assign rf_rb = in_rb;

    // The register file only commits the writeback at the edge, so a same-cycle
    // writeback must bypass the stale read data.
    assign w_fwd_a = wb_valid && (wb_rc == in_ra);
    assign w_fwd_b = wb_valid && (wb_rc == in_rb);
    assign w_fwd_w = wb_valid && (wb_rc == in_rc);
    assign w_op_a  = w_fwd_a ? wb_data : rf_rd1;
    assign w_op_b  = w_fwd_b ? wb_data : rf_rd2;

    assign w_hz_a   = in_use_a && r_busy[in_ra] && !w_fwd_a;
    assign w_hz_b   = in_use_b && r_busy[in_rb] && !w_fwd_b;
    assign w_hz_w   = in_wr && r_busy[in_rc] && !w_fwd_w;
    assign w_space  = !r_out_valid || out_ready;
    assign w_ready  = w_space && !w_hz_a && !w_hz_b && !w_hz_w;
    assign w_accept = in_valid && w_ready;
    assign w_stall  = in_valid && !w_ready;

    // Per-register scoreboard: a new in-flight write takes priority over a retiring one.
    generate
        for (genvar gi = 0; gi < NREGS; gi++) begin : g_busy
            logic w_set;
            logic w_clr;
            assign w_set = w_accept && in_wr && (in_rc == ADDR_WIDTH'(gi));
            assign w_clr = wb_valid && (wb_rc == ADDR_WIDTH'(gi));
            assign w_busy_next[gi] = w_set ? 1'b1 : (w_clr ? 1'b0 : r_busy[gi]);
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_busy <= '0;
        end else begin
            r_busy <= w_busy_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
            r_out_a     <= '0;
            r_out_b     <= '0;
            r_out_rc    <= '0;
            r_out_wr    <= 1'b0;
        end else if (w_accept) begin
            r_out_valid <= 1'b1;
            r_out_a     <= w_op_a;
            r_out_b     <= w_op_b;
            r_out_rc    <= in_rc;
            r_out_wr    <= in_wr;
        end else if (out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stall_count <= '0;
        end else if (w_stall && (r_stall_count != {CNT_WIDTH{1'b1}})) begin
            r_stall_count <= r_stall_count + 1'b1;
        end
    end

    assign in_ready    = w_ready;
    assign out_valid   = r_out_valid;
    assign out_a       = r_out_a;
    assign out_b       = r_out_b;
    assign out_rc      = r_out_rc;
    assign out_wr      = r_out_wr;
    assign busy        = r_busy;
    assign stall_count = r_stall_count;

endmodule

// File: tb/tb_operand_fetch.sv
// Directed bench for operand_fetch: a reference model of the stage state checked every
// cycle, plus hand-computed expectations along the scenario sequence.
module tb_operand_fetch;

    localparam int DW    = 32;
    localparam int AW    = 5;
    localparam int CW    = 4;
    localparam int NREGS = 2**AW;
    localparam int SMAX  = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [AW-1:0] in_ra = '0;
    logic [AW-1:0] in_rb = '0;
    logic [AW-1:0] in_rc = '0;
    logic          in_use_a = 1'b0;
    logic          in_use_b = 1'b0;
    logic          in_wr = 1'b0;
    logic [AW-1:0] rf_ra;
    logic [AW-1:0] rf_rb;
    logic [DW-1:0] rf_rd1 = '0;
    logic [DW-1:0] rf_rd2 = '0;
    logic          wb_valid = 1'b0;
    logic [AW-1:0] wb_rc = '0;
    logic [DW-1:0] wb_data = '0;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic [DW-1:0] out_a;
    logic [DW-1:0] out_b;
    logic [AW-1:0] out_rc;
    logic          out_wr;
    logic [NREGS-1:0] busy;
    logic [CW-1:0] stall_count;

    int  n_total = 0;
    int  n_bad   = 0;
    bit  chk_en  = 1'b0;

    operand_fetch #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .CNT_WIDTH(CW)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_ra(in_ra), .in_rb(in_rb), .in_rc(in_rc),
        .in_use_a(in_use_a), .in_use_b(in_use_b), .in_wr(in_wr),
        .rf_ra(rf_ra), .rf_rb(rf_rb), .rf_rd1(rf_rd1), .rf_rd2(rf_rd2),
        .wb_valid(wb_valid), .wb_rc(wb_rc), .wb_data(wb_data),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_a(out_a), .out_b(out_b), .out_rc(out_rc), .out_wr(out_wr),
        .busy(busy), .stall_count(stall_count)
    );

    always #5 clk = ~clk;

    // Reference state: which registers have a write pending, and the output slot.
    bit          m_pending [NREGS];
    bit          m_valid = 1'b0;
    logic [DW-1:0] m_a = '0;
    logic [DW-1:0] m_b = '0;
    logic [AW-1:0] m_rc = '0;
    bit          m_wr = 1'b0;
    int          m_stall = 0;

    function automatic logic [DW-1:0] src_value(input logic [AW-1:0] r, input logic [DW-1:0] rd);
        return (wb_valid && wb_rc == r) ? wb_data : rd;
    endfunction

    function automatic bit waits_on(input bit used, input logic [AW-1:0] r);
        return used && m_pending[r] && !(wb_valid && wb_rc == r);
    endfunction

    function automatic bit exp_ready();
        bit slot_free;
        slot_free = !m_valid || out_ready;
        return slot_free && !waits_on(in_use_a, in_ra) && !waits_on(in_use_b, in_rb)
               && !waits_on(in_wr, in_rc);
    endfunction

    function automatic logic [NREGS-1:0] pending_vec();
        logic [NREGS-1:0] v;
        for (int i = 0; i < NREGS; i++) v[i] = m_pending[i];
        return v;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREGS; i++) m_pending[i] <= 1'b0;
            m_valid <= 1'b0; m_a <= '0; m_b <= '0; m_rc <= '0; m_wr <= 1'b0;
            m_stall <= 0;
        end else begin
            if (wb_valid) m_pending[wb_rc] <= 1'b0;
            if (in_valid && exp_ready()) begin
                if (in_wr) m_pending[in_rc] <= 1'b1;
                m_valid <= 1'b1;
                m_a  <= src_value(in_ra, rf_rd1);
                m_b  <= src_value(in_rb, rf_rd2);
                m_rc <= in_rc;
                m_wr <= in_wr;
            end else if (out_ready) begin
                m_valid <= 1'b0;
            end
            if (in_valid && !exp_ready() && m_stall < SMAX) m_stall <= m_stall + 1;
        end
    end

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            chk("cyc in_ready", 64'(in_ready), 64'(exp_ready()));
            chk("cyc out_valid", 64'(out_valid), 64'(m_valid));
            chk("cyc out_a", 64'(out_a), 64'(m_a));
            chk("cyc out_b", 64'(out_b), 64'(m_b));
            chk("cyc out_rc", 64'(out_rc), 64'(m_rc));
            chk("cyc out_wr", 64'(out_wr), 64'(m_wr));
            chk("cyc busy", 64'(busy), 64'(pending_vec()));
            chk("cyc stall_count", 64'(stall_count), 64'(m_stall));
            chk("cyc rf_addr", {32'(rf_ra), 32'(rf_rb)}, {32'(in_ra), 32'(in_rb)});
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [AW-1:0] ra, input logic [AW-1:0] rb, input logic [AW-1:0] rc,
                        input bit ua, input bit ub, input bit wr,
                        input logic [DW-1:0] rd1, input logic [DW-1:0] rd2);
        in_valid = 1'b1; in_ra = ra; in_rb = rb; in_rc = rc;
        in_use_a = ua; in_use_b = ub; in_wr = wr; rf_rd1 = rd1; rf_rd2 = rd2;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        #2 rst_n = 1'b0;
        chk_en = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        #1;
        chk("reset out_valid", 64'(out_valid), 64'd0);
        chk("reset out_a", 64'(out_a), 64'd0);
        chk("reset busy", 64'(busy), 64'd0);
        chk("reset stall", 64'(stall_count), 64'd0);
        tick();

        // Basic transfer
        send(1, 2, 3, 1, 1, 1, 32'h11, 32'h22);
        #1 chk("basic ready", 64'(in_ready), 64'd1);
        tick();
        in_valid = 1'b0;
        chk("basic valid", 64'(out_valid), 64'd1);
        chk("basic a", 64'(out_a), 64'h11);
        chk("basic b", 64'(out_b), 64'h22);
        chk("basic rc", 64'(out_rc), 64'd3);
        chk("basic busy", 64'(busy), 64'h8);

        // RAW stall, resolved by forwarding over stale read data
        send(3, 0, 0, 1, 0, 0, 32'h99, 32'h0);
        #1 chk("raw stall", 64'(in_ready), 64'd0);
        repeat (3) tick();
        chk("raw stall count", 64'(stall_count), 64'd3);
        wb_valid = 1'b1; wb_rc = 3; wb_data = 32'hABCD;
        #1 chk("raw fwd ready", 64'(in_ready), 64'd1);
        tick();
        wb_valid = 1'b0; in_valid = 1'b0;
        chk("raw fwd a", 64'(out_a), 64'hABCD);
        chk("raw busy clr", 64'(busy), 64'd0);

        // WAW stall and same-cycle set/clear
        send(0, 0, 5, 0, 0, 1, 32'h44, 32'h45);
        tick();
        chk("waw busy5", 64'(busy), 64'h20);
        #1 chk("waw stall", 64'(in_ready), 64'd0);
        tick();
        wb_valid = 1'b1; wb_rc = 5; wb_data = 32'h55;
        #1 chk("waw release", 64'(in_ready), 64'd1);
        tick();
        wb_valid = 1'b0; in_valid = 1'b0;
        chk("waw set wins", 64'(busy), 64'h20);
        chk("waw out_a", 64'(out_a), 64'h44);

        // Backpressure then back-to-back transfer
        out_ready = 1'b0;
        send(8, 9, 10, 1, 1, 1, 32'h1234, 32'h5678);
        #1 chk("bp ready", 64'(in_ready), 64'd0);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("bp hold a", 64'(out_a), 64'h44);
            chk("bp hold rc", 64'(out_rc), 64'd5);
            chk("bp hold valid", 64'(out_valid), 64'd1);
        end
        out_ready = 1'b1;
        #1 chk("b2b ready", 64'(in_ready), 64'd1);
        tick();
        chk("b2b a", 64'(out_a), 64'h1234);
        chk("b2b b", 64'(out_b), 64'h5678);
        chk("b2b rc", 64'(out_rc), 64'd10);
        chk("b2b busy", 64'(busy), 64'h420);

        // Unused operand on a busy register does not stall
        send(0, 0, 7, 0, 0, 1, 32'h0, 32'h0);
        tick();
        send(7, 0, 0, 0, 0, 0, 32'h70, 32'h0);
        #1 chk("unused ready", 64'(in_ready), 64'd1);
        tick();
        in_valid = 1'b0;
        chk("unused wr", 64'(out_wr), 64'd0);
        chk("unused a", 64'(out_a), 64'h70);
        chk("unused busy", 64'(busy), 64'h4A0);

        // Saturating stall counter, then asynchronous reset mid-stall
        send(7, 0, 0, 1, 0, 0, 32'h77, 32'h0);
        #1 chk("sat stall", 64'(in_ready), 64'd0);
        repeat (8) tick();
        chk("sat count", 64'(stall_count), 64'd15);
        #2 rst_n = 1'b0;
        #1;
        chk("arst valid", 64'(out_valid), 64'd0);
        chk("arst busy", 64'(busy), 64'd0);
        chk("arst stall", 64'(stall_count), 64'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        #1 chk("post rst ready", 64'(in_ready), 64'd1);
        tick();
        in_valid = 1'b0;
        chk("post rst valid", 64'(out_valid), 64'd1);
        chk("post rst a", 64'(out_a), 64'h77);
        repeat (2) tick();

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
